// File: rtl/sram_1r1w_scrub.sv
// sram_1r1w_scrub: 1R1W behavioural SRAM with masked writes, registered held read,
// selectable read-during-write policy and post-reset zero scrub.
module sram_1r1w_scrub #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 64,
  parameter int MASK_W    = 8,
  parameter int RDW_MODE  = 0,
  parameter int INIT_ZERO = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic              W0_en,
  input  logic [DATA_W-1:0] W0_data,
  input  logic [MASK_W-1:0] W0_mask,
  input  logic [ADDR_W-1:0] R0_addr,
  input  logic              R0_en,
  output logic [DATA_W-1:0] R0_data,
  output logic              ready
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int LW    = DATA_W / MASK_W;

  typedef enum logic [1:0] {SCRUB, IDLE_WAIT, READY} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   ram [DEPTH];
  logic [DATA_W-1:0]   bit_mask, old_word, merged, rd_word;
  logic                scrub, wr, rd;

  generate
    if (DATA_W % MASK_W != 0) begin : g_bad_mask
      $fatal(1, "DATA_W must be divisible by MASK_W");
    end
  endgenerate

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= (INIT_ZERO != 0) ? SCRUB : IDLE_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == SCRUB) cnt <= cnt + ADDR_W'(1);
    end

  always_comb
    state_nx = (state == SCRUB) ? ((cnt == ADDR_W'(DEPTH-1)) ? READY : SCRUB) : READY;

  always_comb begin
    ready = state == READY;
    scrub = state == SCRUB;
    wr    = ready & W0_en;
    rd    = ready & R0_en;
  end

  for (genvar k = 0; k < MASK_W; k++) begin : g_lane
    assign bit_mask[k*LW +: LW] = {LW{W0_mask[k]}};
  end

  // Write-first forwards the merged word so the read sees this cycle's write.
  always_comb begin
    old_word = ram[R0_addr];
    merged   = (old_word & ~bit_mask) | (W0_data & bit_mask);
    rd_word  = (RDW_MODE == 0 && wr && W0_addr == R0_addr) ? merged : old_word;
  end

  always_ff @(posedge clock)
    if (scrub) ram[cnt] <= '0;
    else if (wr) ram[W0_addr] <= (ram[W0_addr] & ~bit_mask) | (W0_data & bit_mask);

  always_ff @(posedge clock or posedge reset)
    if (reset) R0_data <= '0;
    else if (rd) R0_data <= rd_word;
endmodule

// File: tb/tb_sram_1r1w_scrub.sv
// tb_sram_1r1w_scrub: directed bench over write-first, read-first and no-scrub instances.
module tb_sram_1r1w_scrub;
  logic        clock = 1'b0, reset = 1'b1;
  logic [3:0]  W0_addr = '0, R0_addr = '0, W0_mask = '0;
  logic        W0_en = 1'b0, R0_en = 1'b0;
  logic [31:0] W0_data = '0;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        ready_a, ready_b, ready_c;
  int          checks = 0, failures = 0;

  always #5 clock = ~clock;

  sram_1r1w_scrub #(.ADDR_W(4), .DATA_W(32), .MASK_W(4), .RDW_MODE(0), .INIT_ZERO(1)) dut_wf (
    .clock(clock), .reset(reset), .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
    .W0_mask(W0_mask), .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(rdata_a), .ready(ready_a));
  sram_1r1w_scrub #(.ADDR_W(4), .DATA_W(32), .MASK_W(4), .RDW_MODE(1), .INIT_ZERO(1)) dut_rf (
    .clock(clock), .reset(reset), .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
    .W0_mask(W0_mask), .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(rdata_b), .ready(ready_b));
  sram_1r1w_scrub #(.ADDR_W(4), .DATA_W(32), .MASK_W(4), .RDW_MODE(0), .INIT_ZERO(0)) dut_nz (
    .clock(clock), .reset(reset), .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
    .W0_mask(W0_mask), .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(rdata_c), .ready(ready_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    W0_addr = a; W0_data = d; W0_mask = m; W0_en = 1'b1;
    @(negedge clock);
    W0_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    R0_addr = a; R0_en = 1'b1;
    @(negedge clock);
    R0_en = 1'b0;
  endtask

  task automatic scrub_count(input string tag);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clock);
      if (i == 1) check({tag, "_nz_ready"}, {31'b0, ready_c}, 32'd1);
      if (i < 16) begin
        check({tag, "_busy"}, {31'b0, ready_a}, 32'd0);
        check({tag, "_rdata0"}, rdata_a, 32'd0);
      end else begin
        check({tag, "_ready_wf"}, {31'b0, ready_a}, 32'd1);
        check({tag, "_ready_rf"}, {31'b0, ready_b}, 32'd1);
      end
    end
  endtask

  initial begin
    // User traffic held throughout reset and scrub must be ignored.
    W0_addr = 4'd3; W0_data = 32'hFFFF_FFFF; W0_mask = 4'hF; W0_en = 1'b1;
    R0_addr = 4'd3; R0_en = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_ready", {31'b0, ready_a}, 32'd0);
    check("rst_rdata", rdata_a, 32'd0);
    check("rst_nz_ready", {31'b0, ready_c}, 32'd0);
    reset = 1'b0;
    check("deassert_nz_ready", {31'b0, ready_c}, 32'd0);
    scrub_count("scrub");
    W0_en = 1'b0; R0_en = 1'b0;
    check("post_scrub_rdata", rdata_a, 32'd0);

    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      check($sformatf("zero_wf_%0d", a), rdata_a, 32'd0);
      check($sformatf("zero_rf_%0d", a), rdata_b, 32'd0);
    end

    wr(4'd5, 32'hAABB_CCDD, 4'b1111);
    wr(4'd5, 32'h1122_3344, 4'b0101);
    R0_addr = 4'd5; R0_en = 1'b1;
    check("mask_latency", rdata_a, 32'd0);
    @(negedge clock);
    R0_en = 1'b0;
    check("mask_wf", rdata_a, 32'hAA22_CC44);
    check("mask_rf", rdata_b, 32'hAA22_CC44);

    wr(4'd5, 32'h5555_5555, 4'b0000);
    rd(4'd5);
    check("mask_zero_noop", rdata_a, 32'hAA22_CC44);

    wr(4'd7, 32'h1234_5678, 4'b1111);
    W0_addr = 4'd7; W0_data = 32'hFFFF_FFFF; W0_mask = 4'b0010; W0_en = 1'b1;
    R0_addr = 4'd7; R0_en = 1'b1;
    @(negedge clock);
    W0_en = 1'b0; R0_en = 1'b0;
    check("rdw_write_first", rdata_a, 32'h1234_FF78);
    check("rdw_read_first", rdata_b, 32'h1234_5678);
    rd(4'd7);
    check("rdw_after_wf", rdata_a, 32'h1234_FF78);
    check("rdw_after_rf", rdata_b, 32'h1234_FF78);

    W0_addr = 4'd9; W0_data = 32'hCAFE_F00D; W0_mask = 4'hF; W0_en = 1'b1;
    R0_addr = 4'd5; R0_en = 1'b1;
    @(negedge clock);
    W0_en = 1'b0; R0_en = 1'b0;
    check("diff_addr_wf", rdata_a, 32'hAA22_CC44);
    check("diff_addr_rf", rdata_b, 32'hAA22_CC44);
    rd(4'd9);
    check("diff_addr_wr", rdata_a, 32'hCAFE_F00D);

    wr(4'd2, 32'h0000_BEEF, 4'hF);
    rd(4'd2);
    check("hold_read", rdata_a, 32'h0000_BEEF);
    wr(4'd2, 32'hDEAD_BEEF, 4'hF);
    check("hold_after_wr", rdata_a, 32'h0000_BEEF);
    @(negedge clock);
    check("hold_idle", rdata_b, 32'h0000_BEEF);
    rd(4'd2);
    check("hold_reread", rdata_a, 32'hDEAD_BEEF);

    // Async reset from READY with non-zero read data.
    reset = 1'b1;
    #1;
    check("areset_rdata", rdata_a, 32'd0);
    check("areset_ready", {31'b0, ready_a}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (9) @(negedge clock);
    check("mid_scrub_busy", {31'b0, ready_a}, 32'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_rdata", rdata_a, 32'd0);
    check("mid_rst_ready", {31'b0, ready_a}, 32'd0);
    check("mid_rst_nz_ready", {31'b0, ready_c}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("mid_deassert_nz", {31'b0, ready_c}, 32'd0);
    scrub_count("rescrub");
    rd(4'd5);
    check("rescrub_zero5", rdata_a, 32'd0);
    rd(4'd15);
    check("rescrub_zero15", rdata_b, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_1r1w_scrub.md
Name: sram_1r1w_scrub

Overview:
Parametrised single-clock 1-read/1-write behavioural SRAM macro. It generalises the fixed-geometry `*_ext` memories to arbitrary width, depth and mask granularity. It adds:
- a registered, held read port;
- a selectable read-during-write policy;
- a post-reset zero-scrub state machine.

It serves cache data/tag arrays and scratchpads that need deterministic contents after reset.

Parameters:
- ADDR_W, 6: address width; depth = 2**ADDR_W.
- DATA_W, 64: word width.
- MASK_W, 8: write-mask lanes. DATA_W must be divisible by MASK_W; lane width LW = DATA_W/MASK_W.
- RDW_MODE, 0: same-address read-during-write policy. 0 = write-first (merged new data), 1 = read-first (old data).
- INIT_ZERO, 1: 1 = scrub every word to zero after reset; 0 = no scrub.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- W0_addr  in  ADDR_W  write address.
- W0_en  in  1  write enable.
- W0_data  in  DATA_W  write data.
- W0_mask  in  MASK_W  lane enables; bit k covers bits [k*LW+LW-1 : k*LW].
- R0_addr  in  ADDR_W  read address.
- R0_en  in  1  read enable.
- R0_data  out  DATA_W  registered read data.
- ready  out  1  array accepts accesses.

Behaviour:
- Reset values:
  - R0_data = 0; ready = 0.
  - FSM = SCRUB if INIT_ZERO=1, else IDLE_WAIT.
  - Scrub counter = 0.
  - Array contents are not reset by the reset pin.
- FSM:
  - SCRUB: each cycle writes all-zero (full mask) to ram[cnt] and increments cnt. When cnt == 2**ADDR_W-1 that write completes and the FSM moves to READY.
  - IDLE_WAIT (INIT_ZERO=0): one cycle, then READY.
  - READY: terminal until reset.
- ready is 1 only in READY. It rises on the clock edge after the last scrub write, so scrub takes exactly 2**ADDR_W cycles after reset deassertion.
- While ready = 0:
  - W0_en and R0_en are ignored; no user write reaches the array.
  - R0_data holds 0.
- Reset asserted mid-scrub: FSM and counter return to their reset values immediately. Scrub restarts at address 0 after deassertion.
- Write, in READY: at a rising edge with W0_en = 1, each lane k with W0_mask[k] = 1 is updated. Lanes with mask 0 are unchanged. W0_en = 1 with mask 0 is a no-op.
- Read, in READY:
  - At a rising edge with R0_en = 1, R0_data <= ram[R0_addr]. Latency is 1 cycle.
  - R0_data holds its value while R0_en = 0, even if the addressed word is later written.
- Simultaneous W0_en and R0_en to the same address in one cycle:
  - RDW_MODE = 0: R0_data = old word with masked lanes replaced by W0_data lanes.
  - RDW_MODE = 1: R0_data = old word.
- Simultaneous accesses to different addresses: independent, no interaction.
- Address width fully decodes the depth; no out-of-range case exists.
- Elaboration check: DATA_W % MASK_W != 0 is a fatal error.

Test Plan:
Configuration for all scenarios unless noted: ADDR_W=4, DATA_W=32, MASK_W=4, INIT_ZERO=1.

1. Scrub and reset timing:
   - Deassert reset, then hold R0_en = 1 at addr 3 and W0_en = 1 at addr 3 with data 0xFFFFFFFF throughout scrub.
   - Required: ready = 0 for exactly 16 cycles and rises on the 16th edge.
   - Required: R0_data = 0 throughout scrub.
   - Required: a read of every address after ready returns 0x00000000 (the write during scrub was ignored).
2. Masked write:
   - Write 0xAABBCCDD to addr 5 with mask 4'b1111.
   - Then write 0x11223344 to addr 5 with mask 4'b0101.
   - Read addr 5 -> 0xAA22CC44, one cycle after R0_en.
3. Read-during-write, RDW_MODE = 0:
   - addr 7 holds 0x12345678.
   - In the same cycle, write 0xFFFFFFFF with mask 4'b0010 and read addr 7 -> R0_data = 0x1234FF78.
4. Read-during-write, RDW_MODE = 1:
   - Same stimulus as scenario 3 -> R0_data = 0x12345678.
   - A subsequent read of addr 7 -> 0x1234FF78.
5. Hold behaviour:
   - Read addr 2 (value 0x0000BEEF).
   - Drop R0_en and write 0xDEADBEEF to addr 2.
   - R0_data stays 0x0000BEEF until the next R0_en.
6. Reset mid-scrub:
   - Assert reset at scrub count 9 for 2 cycles.
   - Required: R0_data = 0 and ready = 0 immediately.
   - Required: ready rises exactly 16 cycles after deassertion.
   - With INIT_ZERO=0: ready rises 1 cycle after deassertion.
